// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared digit indices, conversion FSM states and segment codes for the time display
package display_pkg;

  localparam logic [2:0] DIG_MIN_T = 3'd5;
  localparam logic [2:0] DIG_MIN_O = 3'd4;
  localparam logic [2:0] DIG_SEC_T = 3'd3;
  localparam logic [2:0] DIG_SEC_O = 3'd2;
  localparam logic [2:0] DIG_CS_T  = 3'd1;
  localparam logic [2:0] DIG_CS_O  = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SNAP     = 3'd1,
    ST_CONV_MIN = 3'd2,
    ST_CONV_SEC = 3'd3,
    ST_CONV_CS  = 3'd4,
    ST_COMMIT   = 3'd5
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry [d] is the pattern for decimal digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low 7-segment pattern, non-decimal codes blank
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - MM.SS.CC multiplexed 7-segment scanner with per-frame BCD conversion
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module time_display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int CS_MAX  = 99
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [6:0] m_seconds,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [6:0] CS_CLAMP = 7'(CS_MAX);

  logic [PW-1:0] presc;
  logic          tick;
  logic [2:0]    idx;
  logic [2:0]    next_idx;
  logic          frame_start;

  conv_state_t state, state_n;

  logic [6:0] rem_min, rem_sec, rem_cs;
  logic [3:0] tens_min, tens_sec, tens_cs;
  logic [3:0] ones_min, ones_sec, ones_cs;
  logic [3:0] disp [0:5];
  logic [6:0] dec_seg;

  assign tick        = (presc == PW'(CLK_DIV - 1));
  assign next_idx    = (idx == 3'd0) ? DIG_MIN_T : idx - 3'd1;
  assign frame_start = tick && (idx == 3'd0);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge m_clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (tick) begin
      presc <= '0;
      idx   <= next_idx;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (frame_start) state_n = ST_SNAP;
      ST_SNAP:     state_n = ST_CONV_MIN;
      ST_CONV_MIN: if (rem_min < 7'd10) state_n = ST_CONV_SEC;
      ST_CONV_SEC: if (rem_sec < 7'd10) state_n = ST_CONV_CS;
      ST_CONV_CS:  if (rem_cs < 7'd10) state_n = ST_COMMIT;
      ST_COMMIT:   state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // Shadow registers isolate the frame in progress from live input changes.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      rem_min  <= '0;
      rem_sec  <= '0;
      rem_cs   <= '0;
      tens_min <= '0;
      tens_sec <= '0;
      tens_cs  <= '0;
      ones_min <= '0;
      ones_sec <= '0;
      ones_cs  <= '0;
      for (int i = 0; i < 6; i++) disp[i] <= '0;
    end else begin
      case (state)
        ST_SNAP: begin
          rem_min  <= {1'b0, minutes};
          rem_sec  <= {1'b0, seconds};
          rem_cs   <= (m_seconds > CS_CLAMP) ? CS_CLAMP : m_seconds;
          tens_min <= '0;
          tens_sec <= '0;
          tens_cs  <= '0;
        end
        ST_CONV_MIN: begin
          if (rem_min >= 7'd10) begin
            rem_min  <= rem_min - 7'd10;
            tens_min <= tens_min + 4'd1;
          end else begin
            ones_min <= rem_min[3:0];
          end
        end
        ST_CONV_SEC: begin
          if (rem_sec >= 7'd10) begin
            rem_sec  <= rem_sec - 7'd10;
            tens_sec <= tens_sec + 4'd1;
          end else begin
            ones_sec <= rem_sec[3:0];
          end
        end
        ST_CONV_CS: begin
          if (rem_cs >= 7'd10) begin
            rem_cs  <= rem_cs - 7'd10;
            tens_cs <= tens_cs + 4'd1;
          end else begin
            ones_cs <= rem_cs[3:0];
          end
        end
        ST_COMMIT: begin
          disp[DIG_MIN_T] <= tens_min;
          disp[DIG_MIN_O] <= ones_min;
          disp[DIG_SEC_T] <= tens_sec;
          disp[DIG_SEC_O] <= ones_sec;
          disp[DIG_CS_T]  <= tens_cs;
          disp[DIG_CS_O]  <= ones_cs;
        end
        default: ;
      endcase
    end
  end

  seg7_decoder u_dec (
    .digit (disp[next_idx]),
    .seg   (dec_seg)
  );

  // seg, dp and an all load on the same tick so a digit never shows in the wrong slot.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 6'h3F;
    end else if (tick) begin
      an <= ~(6'b000001 << next_idx);
      dp <= ~((next_idx == DIG_MIN_O) || (next_idx == DIG_SEC_O));
`ifdef LEADING_ZERO_BLANK_EN
      if ((next_idx == DIG_MIN_T) && (disp[DIG_MIN_T] == 4'd0)) begin
        seg <= SEG_BLANK;
      end else begin
        seg <= dec_seg;
      end
`else
      seg <= dec_seg;
`endif
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// tb/tb_time_display_scan.sv - scoreboard bench for time_display_scan against an arithmetic display model
module tb_time_display_scan;

  localparam int CLK_DIV = 8;
  localparam int CS_MAX  = 99;

  logic       m_clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [6:0] m_seconds = '0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  always #5 m_clk = ~m_clk;

  time_display_scan #(.CLK_DIV(CLK_DIV), .CS_MAX(CS_MAX)) dut (
    .m_clk     (m_clk),
    .reset     (reset),
    .minutes   (minutes),
    .seconds   (seconds),
    .m_seconds (m_seconds),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .busy      (busy)
  );

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: slot timing from edge counting, digits from plain /10 and %10.
  int    edge_cnt;
  int    slot;
  int    committed [6];
  int    pending [6];
  int    commit_at = -1;
  int    snap_at = -1;
  disp_t e_model;

  always @(posedge m_clk) begin
    if (reset) begin
      edge_cnt  = 0;
      slot      = 0;
      commit_at = -1;
      snap_at   = -1;
      for (int i = 0; i < 6; i++) committed[i] = 0;
      exp_q.delete();
    end else begin
      int m, s, c;
      edge_cnt++;
      if (edge_cnt % CLK_DIV == 0) begin
        slot = (slot == 0) ? 5 : slot - 1;
        e_model.an  = ~(6'b000001 << slot);
        e_model.seg = seg_of(committed[slot]);
        e_model.dp  = (slot == 4 || slot == 2) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 5 && committed[5] == 0) e_model.seg = 7'h7F;
`endif
        exp_q.push_back(e_model);
        if (slot == 5) snap_at = edge_cnt + 1;
      end
      if (edge_cnt == commit_at) committed = pending;
      if (edge_cnt == snap_at) begin
        m = int'(minutes);
        s = int'(seconds);
        c = (int'(m_seconds) > CS_MAX) ? CS_MAX : int'(m_seconds);
        pending[5] = m / 10; pending[4] = m % 10;
        pending[3] = s / 10; pending[2] = s % 10;
        pending[1] = c / 10; pending[0] = c % 10;
        commit_at = edge_cnt + 4 + m / 10 + s / 10 + c / 10;
      end
    end
  end

  logic [5:0] prev_an = 6'h3F;

  always @(negedge m_clk) begin
    if (an !== prev_an) begin
      if (reset) begin
        check("reset_an", an, 6'h3F);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_scan", an, prev_an);
      end else begin
        disp_t got;
        got = exp_q.pop_front();
        check("scan_an", an, got.an);
        check("scan_seg", seg, got.seg);
        check("scan_dp", dp, got.dp);
      end
      prev_an = an;
    end
  end

  task automatic run_frames(input int n);
    repeat (n * 6 * CLK_DIV) @(negedge m_clk);
  endtask

  task automatic wait_busy_rise();
    bit was, ok;
    ok  = 1'b0;
    was = busy;
    for (int i = 0; i < 16 * CLK_DIV; i++) begin
      @(negedge m_clk);
      if (busy && !was) begin
        ok = 1'b1;
        break;
      end
      was = busy;
    end
    check("busy_rise_seen", ok, 1'b1);
  endtask

  task automatic set_inputs(input int m, input int s, input int c);
    minutes   = 6'(m);
    seconds   = 6'(s);
    m_seconds = 7'(c);
  endtask

  initial begin
    set_inputs(12, 34, 56);
    reset = 1'b1;
    repeat (3) @(negedge m_clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 6'h3F);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    run_frames(2);

    set_inputs(63, 7, 120);
    run_frames(2);

    set_inputs(0, 0, 0);
    run_frames(1);
    wait_busy_rise();
    @(negedge m_clk);
    set_inputs(59, 59, 59);
    run_frames(2);

    set_inputs(47, 59, 99);
    run_frames(2);
    set_inputs(0, 59, 0);
    wait_busy_rise();
    @(negedge m_clk);
    @(negedge m_clk);
    reset = 1'b1;
    @(negedge m_clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_an", an, 6'h3F);
    @(negedge m_clk);
    reset = 1'b0;
    run_frames(2);

    set_inputs(5, 0, 0);
    run_frames(2);
    set_inputs(10, 0, 0);
    run_frames(2);

    for (int k = 0; k < 40; k++) begin
      set_inputs($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 127));
      repeat ($urandom_range(1, 60)) @(negedge m_clk);
    end
    run_frames(2);

    @(negedge m_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
